// File: rtl/efpga_frame_loader_pkg.sv
// efpga_frame_loader_pkg: shared constants, header field layout and FSM states
package efpga_frame_loader_pkg;

    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

    localparam int HDR_FIELD_W   = 5;
    localparam int HDR_COL_LSB   = 0;
    localparam int HDR_FIRST_LSB = 8;
    localparam int HDR_CNT_LSB   = 16;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } state_t;

endpackage

// File: rtl/efpga_header_check.sv
// efpga_header_check: combinational header field decode and frame-range check
module efpga_header_check
    import efpga_frame_loader_pkg::*;
#(
    parameter int NUM_COLUMNS        = 16,
    parameter int MAX_FRAMES_PER_COL = 20
) (
    input  logic [31:0]            word_i,
    output logic [HDR_FIELD_W-1:0] col_o,
    output logic [HDR_FIELD_W-1:0] first_o,
    output logic [HDR_FIELD_W-1:0] cnt_o,
    output logic                   valid_o
);

    logic [5:0] end_frame;
    logic       unused_bits;

    assign col_o       = word_i[HDR_COL_LSB +: HDR_FIELD_W];
    assign first_o     = word_i[HDR_FIRST_LSB +: HDR_FIELD_W];
    assign cnt_o       = word_i[HDR_CNT_LSB +: HDR_FIELD_W];
    assign unused_bits = ^{word_i[31:21], word_i[15:13], word_i[7:5]};
    // cnt_o holds count-1, so the exclusive end of the frame range is first + cnt + 1
    assign end_frame   = {1'b0, first_o} + {1'b0, cnt_o} + 6'd1;
    assign valid_o     = ({1'b0, col_o} < 6'(NUM_COLUMNS)) && (end_frame <= 6'(MAX_FRAMES_PER_COL));

endmodule

// File: rtl/efpga_frame_loader.sv
// efpga_frame_loader: sync/header/data word parser steering rows and frame strobes into the eFPGA
module efpga_frame_loader
    import efpga_frame_loader_pkg::*;
#(
    parameter int NUM_COLUMNS        = 16,
    parameter int MAX_FRAMES_PER_COL = 20,
    parameter int NUM_ROWS           = 16,
    parameter int ROW_W              = $clog2(NUM_ROWS)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [31:0]      write_data_i,
    input  logic             write_strobe_i,
    output logic [31:0]      row_data_o,
    output logic [ROW_W-1:0] row_select_o,
    output logic             row_strobe_o,
    output logic [4:0]       frame_col_o,
    output logic [4:0]       frame_idx_o,
    output logic             frame_strobe_o,
    output logic             active_o,
    output logic             error_o
);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [4:0]       col_q, col_d;
    logic [4:0]       idx_q, idx_d;
    logic [4:0]       rem_q, rem_d;
    logic             fpend_q, fpend_d;
    logic [31:0]      row_data_q, row_data_d;
    logic [ROW_W-1:0] row_select_q, row_select_d;
    logic             row_strobe_q, row_strobe_d;
    logic [4:0]       frame_col_q, frame_col_d;
    logic [4:0]       frame_idx_q, frame_idx_d;
    logic             frame_strobe_q, frame_strobe_d;
    logic             active_q, active_d;
    logic             error_q, error_d;

    logic [4:0] hdr_col, hdr_first, hdr_cnt;
    logic       hdr_valid;
    logic       last_row;

    efpga_header_check #(
        .NUM_COLUMNS       (NUM_COLUMNS),
        .MAX_FRAMES_PER_COL(MAX_FRAMES_PER_COL)
    ) u_header_check (
        .word_i (write_data_i),
        .col_o  (hdr_col),
        .first_o(hdr_first),
        .cnt_o  (hdr_cnt),
        .valid_o(hdr_valid)
    );

    assign last_row = row_q == ROW_W'(NUM_ROWS - 1);

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        col_d          = col_q;
        idx_d          = idx_q;
        rem_d          = rem_q;
        fpend_d        = 1'b0;
        row_data_d     = row_data_q;
        row_select_d   = row_select_q;
        row_strobe_d   = 1'b0;
        frame_col_d    = frame_col_q;
        frame_idx_d    = frame_idx_q;
        frame_strobe_d = 1'b0;
        active_d       = active_q;
        error_d        = error_q;
        // frame strobe trails the last row strobe by one cycle; frame advance happens here too
        if (fpend_q) begin
            frame_strobe_d = 1'b1;
            frame_col_d    = col_q;
            frame_idx_d    = idx_q;
            idx_d          = idx_q + 5'd1;
            rem_d          = rem_q - 5'd1;
            active_d       = rem_q != 5'd0;
        end
        if (write_strobe_i) begin
            case (state_q)
                IDLE: begin
                    if (write_data_i == SYNC) begin
                        error_d = 1'b0;
                        state_d = HEADER;
                    end
                end
                HEADER: begin
                    if (write_data_i == DESYNC) begin
                        state_d = IDLE;
                    end else if (write_data_i != SYNC) begin
                        state_d = hdr_valid ? DATA : IDLE;
                        error_d = !hdr_valid;
                        if (hdr_valid) begin
                            col_d    = hdr_col;
                            idx_d    = hdr_first;
                            rem_d    = hdr_cnt;
                            row_d    = '0;
                            active_d = 1'b1;
                        end
                    end
                end
                DATA: begin
                    row_data_d   = write_data_i;
                    row_select_d = row_q;
                    row_strobe_d = 1'b1;
                    row_d        = last_row ? '0 : row_q + 1'b1;
                    fpend_d      = last_row;
                    if (last_row && rem_q == 5'd0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= IDLE;
            row_q          <= '0;
            col_q          <= '0;
            idx_q          <= '0;
            rem_q          <= '0;
            fpend_q        <= 1'b0;
            row_data_q     <= '0;
            row_select_q   <= '0;
            row_strobe_q   <= 1'b0;
            frame_col_q    <= '0;
            frame_idx_q    <= '0;
            frame_strobe_q <= 1'b0;
            active_q       <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            col_q          <= col_d;
            idx_q          <= idx_d;
            rem_q          <= rem_d;
            fpend_q        <= fpend_d;
            row_data_q     <= row_data_d;
            row_select_q   <= row_select_d;
            row_strobe_q   <= row_strobe_d;
            frame_col_q    <= frame_col_d;
            frame_idx_q    <= frame_idx_d;
            frame_strobe_q <= frame_strobe_d;
            active_q       <= active_d;
            error_q        <= error_d;
        end
    end

    assign row_data_o     = row_data_q;
    assign row_select_o   = row_select_q;
    assign row_strobe_o   = row_strobe_q;
    assign frame_col_o    = frame_col_q;
    assign frame_idx_o    = frame_idx_q;
    assign frame_strobe_o = frame_strobe_q;
    assign active_o       = active_q;
    assign error_o        = error_q;

endmodule

// File: tb/tb_efpga_frame_loader.sv
// tb_efpga_frame_loader: directed vector table plus multi-cycle frame sequences
module tb_efpga_frame_loader;

    localparam int NR = 16;
    localparam int RW = 4;
    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   write_data = '0;
    logic          write_strobe = 1'b0;
    logic [31:0]   row_data_o;
    logic [RW-1:0] row_select_o;
    logic          row_strobe_o;
    logic [4:0]    frame_col_o;
    logic [4:0]    frame_idx_o;
    logic          frame_strobe_o;
    logic          active_o;
    logic          error_o;

    int checks = 0;
    int errors = 0;

    logic [35:0] rq[$];
    logic [11:0] fq[$];

    typedef struct {
        logic        ws;
        logic [31:0] wd;
        logic        act;
        logic        err;
    } vec_t;

    vec_t tbl[17];

    efpga_frame_loader #(
        .NUM_COLUMNS       (16),
        .MAX_FRAMES_PER_COL(20),
        .NUM_ROWS          (NR),
        .ROW_W             (RW)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .write_data_i  (write_data),
        .write_strobe_i(write_strobe),
        .row_data_o    (row_data_o),
        .row_select_o  (row_select_o),
        .row_strobe_o  (row_strobe_o),
        .frame_col_o   (frame_col_o),
        .frame_idx_o   (frame_idx_o),
        .frame_strobe_o(frame_strobe_o),
        .active_o      (active_o),
        .error_o       (error_o)
    );

    always #5 clk = ~clk;

    // record every row/frame strobe; the frame record notes active_o and a coinciding row-0 strobe
    always @(negedge clk) begin
        if (row_strobe_o) rq.push_back({row_select_o, row_data_o});
        if (frame_strobe_o) fq.push_back({frame_col_o, frame_idx_o, active_o, row_strobe_o && row_select_o == '0});
    end

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic ws, input logic [31:0] wd);
        write_strobe = ws;
        write_data   = wd;
        @(posedge clk);
        #1;
        write_strobe = 1'b0;
    endtask

    task automatic xfer(input logic [4:0] col, input logic [4:0] first, input logic [4:0] cm1,
                        input logic [31:0] base, input int gap, input int special, input bit overlap);
        int n = (int'(cm1) + 1) * NR;
        logic [31:0] d;
        logic [11:0] e;
        rq.delete();
        fq.delete();
        step(1'b1, SYNC);
        step(1'b1, {11'h0, cm1, 3'b0, first, 3'b0, col});
        chk("hdr_active", 36'(active_o), 36'd1);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(gap, 0)) step(1'b0, SYNC);
            d = base + 32'(k);
            if (special >= 0 && k == special) d = SYNC;
            if (special >= 0 && k == special + 1) d = DESYNC;
            step(1'b1, d);
        end
        step(1'b0, '0);
        step(1'b0, '0);
        chk("row_count", 36'(rq.size()), 36'(n));
        for (int k = 0; k < n && k < rq.size(); k++) begin
            d = base + 32'(k);
            if (special >= 0 && k == special) d = SYNC;
            if (special >= 0 && k == special + 1) d = DESYNC;
            chk($sformatf("row%0d", k), rq[k], {RW'(k % NR), d});
        end
        chk("frame_count", 36'(fq.size()), 36'(int'(cm1) + 1));
        for (int f = 0; f <= int'(cm1) && f < fq.size(); f++) begin
            e = {col, 5'(int'(first) + f), f != int'(cm1), f != int'(cm1)};
            chk($sformatf("frame%0d", f), overlap ? 36'(fq[f]) : 36'(fq[f][11:1]),
                overlap ? 36'(e) : 36'(e[11:1]));
        end
        chk("end_active", 36'(active_o), 36'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h1234_5678, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, SYNC,          1'b0, 1'b0};
        tbl[2]  = '{1'b1, SYNC,          1'b0, 1'b0};
        tbl[3]  = '{1'b1, 32'h0000_0010, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 32'h0000_0503, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, SYNC,          1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'h0001_1300, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, SYNC,          1'b0, 1'b0};
        tbl[8]  = '{1'b1, DESYNC,        1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'h0000_0503, 1'b0, 1'b0};
        tbl[10] = '{1'b0, SYNC,          1'b0, 1'b0};
        tbl[11] = '{1'b1, 32'h0000_0001, 1'b0, 1'b0};
        tbl[12] = '{1'b1, SYNC,          1'b0, 1'b0};
        tbl[13] = '{1'b0, 32'h0000_0503, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 32'h0000_1400, 1'b0, 1'b1};
        tbl[15] = '{1'b1, SYNC,          1'b0, 1'b0};
        tbl[16] = '{1'b1, 32'h0000_130F, 1'b1, 1'b0};

        #12;
        chk("reset_outs", {row_data_o, row_strobe_o, frame_strobe_o, active_o, error_o}, '0);
        reset_n = 1'b1;

        rq.delete();
        fq.delete();
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].ws, tbl[i].wd);
            chk($sformatf("vec%0d", i), {row_strobe_o, frame_strobe_o, active_o, error_o},
                {2'b00, tbl[i].act, tbl[i].err});
        end
        chk("vec_no_rows", 36'(rq.size()), 36'd0);

        // boundary header (col 15, frames 19..19) accepted by the last vector
        for (int k = 0; k < NR; k++) step(1'b1, 32'hC0DE_0000 + 32'(k));
        chk("bnd_last_row", {row_strobe_o, row_select_o, row_data_o, frame_strobe_o, active_o},
            {1'b1, RW'(NR - 1), 32'hC0DE_000F, 1'b0, 1'b1});
        step(1'b0, '0);
        chk("bnd_frame", {row_strobe_o, frame_strobe_o, frame_col_o, frame_idx_o, active_o},
            {1'b0, 1'b1, 5'd15, 5'd19, 1'b0});
        step(1'b0, '0);
        chk("bnd_hold", {frame_strobe_o, frame_col_o, frame_idx_o, row_data_o},
            {1'b0, 5'd15, 5'd19, 32'hC0DE_000F});

        xfer(5'd3, 5'd5, 5'd0, 32'h0, 0, -1, 1'b1);
        rq.delete();
        step(1'b1, 32'h0000_0503);
        step(1'b1, 32'h0000_0007);
        step(1'b0, '0);
        chk("idle_ignore", {28'(rq.size()), 7'd0, active_o}, '0);

        xfer(5'd2, 5'd0, 5'd2, 32'h0000_1000, 0, -1, 1'b1);
        xfer(5'd9, 5'd7, 5'd0, 32'h5500_0000, 0, 4, 1'b1);
        xfer(5'd2, 5'd0, 5'd1, 32'h0000_1000, 5, -1, 1'b0);

        rq.delete();
        step(1'b1, SYNC);
        step(1'b1, 32'h0000_0001);
        for (int k = 0; k < 7; k++) step(1'b1, 32'hBEEF_0000 + 32'(k));
        chk("pre_reset", {row_strobe_o, row_select_o, active_o}, {1'b1, RW'(6), 1'b1});
        reset_n = 1'b0;
        #2;
        chk("async_reset", {row_data_o, row_select_o, row_strobe_o, frame_col_o, frame_idx_o,
            frame_strobe_o, active_o, error_o} == '0, 36'd1);
        @(negedge clk);
        reset_n = 1'b1;
        rq.delete();
        step(1'b1, 32'h0000_0001);
        step(1'b1, 32'h0000_0002);
        step(1'b0, '0);
        chk("post_reset_quiet", {28'(rq.size()), 7'd0, active_o}, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
